// File: rtl/conv_seq_pkg.sv
// Shared definitions for the sequential conv + ReLU + 2x2 max-pool layer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the FSM state encodings and the helpers used to size counters and
// address buses from the layer geometry.
package conv_seq_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_POOL  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Width needed to hold 0..n-1.
    // Never returns 0, so that a degenerate dimension of 1 still gets a
    // legal one-bit bus.
    function automatic int aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of valid convolution output positions along one axis
    function automatic int conv_out(input int dim, input int k);
        return dim - k + 1;
    endfunction

    // Number of pooled outputs along one axis (2x2 pooling, floor)
    function automatic int pool_out(input int dim, input int k);
        return conv_out(dim, k) / 2;
    endfunction

endpackage

// File: rtl/conv_mac_acc.sv
// Shared signed MAC with ReLU and running max across the four 2x2 pool positions.
// Latency: one cycle per accumulate; max_q reflects a pool step on the following cycle.
// Backpressure: none; all control comes from the sequencer's strobes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din, kin          input word (IBW signed) and kernel word (KBW+1 signed)
//   acc_clr           zero the accumulator (wins over acc_en)
//   acc_en            acc += din*kin
//   pool_en           max <= max(max, relu(acc))
//   max_clr           zero the running max (wins over pool_en)
//   max_q             current running max (the pooled result)
module conv_mac_acc
    import conv_seq_pkg::*;
#(
    parameter int IBW = 8,
    parameter int KBW = 64,
    parameter int OBW = IBW + KBW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IBW-1:0] din,
    input  logic [KBW:0]   kin,
    input  logic           acc_clr,
    input  logic           acc_en,
    input  logic           pool_en,
    input  logic           max_clr,
    output logic [OBW:0]   max_q
);

    logic signed [OBW:0] din_x;
    logic signed [OBW:0] kin_x;
    logic signed [OBW:0] prod;
    logic signed [OBW:0] acc;
    logic        [OBW:0] relu;

    // Sign-extend both operands to the full result width before
    // multiplying.
    // The exact product of IBW x (KBW+1) signed bits always fits in OBW+1
    // bits, so the truncated full-width multiply is exact.
    assign din_x = {{(OBW + 1 - IBW){din[IBW-1]}}, din};
    assign kin_x = {{(OBW - KBW){kin[KBW]}}, kin};
    assign prod  = din_x * kin_x;

    // ReLU of the finished window sum
    assign relu = acc[OBW] ? '0 : acc;

    // Accumulation wraps modulo 2^(OBW+1) by construction
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + prod;
        end
    end

    // Both operands are non-negative after ReLU, so an unsigned compare
    // is correct.
    always_ff @(posedge clk) begin
        if (rst || max_clr) begin
            max_q <= '0;
        end else if (pool_en && (relu > max_q)) begin
            max_q <= relu;
        end
    end

endmodule

// File: rtl/conv_pool_sequencer.sv
// Sequential conv + ReLU + 2x2 max-pool: one shared MAC, one RAM word per cycle, pooled results streamed out.
// Latency: 4*(N+2)+1 cycles per pooled result with res_ready high; the first result is valid 4*(N+2)+1 cycles after start.
// Backpressure: res_valid/res_ready; EMIT holds res_data/res_addr stable and stalls the whole pipeline until ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a pass (only sampled in IDLE)
//   busy, done               pass in progress / one-cycle completion pulse
//   in_rd_en/in_addr/in_data input RAM port (1-cycle read latency)
//   k_rd_en/k_addr/k_data    kernel RAM port (1-cycle read latency)
//   res_valid/res_ready      result handshake
//   res_addr/res_data        result address and value
module conv_pool_sequencer
    import conv_seq_pkg::*;
#(
    parameter int IBW      = 8,
    parameter int KBW      = 64,
    parameter int OBW      = IBW + KBW,
    parameter int HEIGHT   = 28,
    parameter int WIDTH    = 28,
    parameter int CHANNELS = 1,
    parameter int FILTERS  = 32,
    parameter int K_X      = 3,
    parameter int K_Y      = 3
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       start,
    output logic                                                       busy,
    output logic                                                       done,
    output logic                                                       in_rd_en,
    output logic [aw(CHANNELS*HEIGHT*WIDTH)-1:0]                       in_addr,
    input  logic [IBW-1:0]                                             in_data,
    output logic                                                       k_rd_en,
    output logic [aw(FILTERS*CHANNELS*K_X*K_Y)-1:0]                    k_addr,
    input  logic [KBW:0]                                               k_data,
    output logic                                                       res_valid,
    input  logic                                                       res_ready,
    output logic [aw(FILTERS*pool_out(HEIGHT,K_X)*pool_out(WIDTH,K_Y))-1:0] res_addr,
    output logic [OBW:0]                                               res_data
);

    localparam int PX     = pool_out(HEIGHT, K_X);
    localparam int PY     = pool_out(WIDTH, K_Y);
    localparam int IN_AW  = aw(CHANNELS * HEIGHT * WIDTH);
    localparam int K_AW   = aw(FILTERS * CHANNELS * K_X * K_Y);
    localparam int R_AW   = aw(FILTERS * PX * PY);
    localparam int TW     = aw(K_Y);
    localparam int KW     = aw(K_X);
    localparam int CW     = aw(CHANNELS);
    localparam int PCW    = aw(PY);
    localparam int PRW    = aw(PX);
    localparam int FW     = aw(FILTERS);

    localparam logic [TW-1:0]  T_LAST  = TW'(K_Y - 1);
    localparam logic [KW-1:0]  K_LAST  = KW'(K_X - 1);
    localparam logic [CW-1:0]  C_LAST  = CW'(CHANNELS - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PY - 1);
    localparam logic [PRW-1:0] PR_LAST = PRW'(PX - 1);
    localparam logic [FW-1:0]  F_LAST  = FW'(FILTERS - 1);

    logic [2:0]     state;
    logic [TW-1:0]  t;      // kernel column, innermost
    logic [KW-1:0]  k;      // kernel row
    logic [CW-1:0]  c;      // channel
    logic           dx;     // pool window row offset
    logic           dy;     // pool window column offset, innermost
    logic [PCW-1:0] pc;     // pooled column
    logic [PRW-1:0] pr;     // pooled row
    logic [FW-1:0]  f;      // filter
    logic           rd_q;   // read issued last cycle: RAM data valid now

    logic fetch_last;
    logic res_last;
    logic start_acc;
    logic hs;

    logic [IN_AW-1:0] in_row;
    logic [IN_AW-1:0] in_col;

    assign fetch_last = (t == T_LAST) && (k == K_LAST) && (c == C_LAST);
    assign res_last   = (pc == PC_LAST) && (pr == PR_LAST) && (f == F_LAST);
    assign start_acc  = (state == S_IDLE) && start;
    assign hs         = (state == S_EMIT) && res_ready;

    // Address generation.
    // Every counter is zero in reset and idle, so all addresses read 0
    // there too.
    assign in_row  = IN_AW'(2) * IN_AW'(pr) + IN_AW'(dx) + IN_AW'(k);
    assign in_col  = IN_AW'(2) * IN_AW'(pc) + IN_AW'(dy) + IN_AW'(t);
    assign in_addr = IN_AW'(c) * IN_AW'(HEIGHT * WIDTH) + in_row * IN_AW'(WIDTH) + in_col;

    assign k_addr = ((K_AW'(f) * K_AW'(CHANNELS) + K_AW'(c)) * K_AW'(K_X) + K_AW'(k))
                    * K_AW'(K_Y) + K_AW'(t);

    assign res_addr = R_AW'(f) * R_AW'(PX * PY) + R_AW'(pr) * R_AW'(PY) + R_AW'(pc);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign in_rd_en  = (state == S_FETCH);
    assign k_rd_en   = (state == S_FETCH);
    assign res_valid = (state == S_EMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            t     <= '0;
            k     <= '0;
            c     <= '0;
            dx    <= 1'b0;
            dy    <= 1'b0;
            pc    <= '0;
            pr    <= '0;
            f     <= '0;
            rd_q  <= 1'b0;
        end else begin
            rd_q <= (state == S_FETCH);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        t     <= '0;
                        k     <= '0;
                        c     <= '0;
                        dx    <= 1'b0;
                        dy    <= 1'b0;
                        pc    <= '0;
                        pr    <= '0;
                        f     <= '0;
                    end
                end
                S_FETCH: begin
                    // t innermost, then k, then c; everything wraps to 0
                    // on the last tap.
                    if (t == T_LAST) begin
                        t <= '0;
                        if (k == K_LAST) begin
                            k <= '0;
                            if (c == C_LAST) begin
                                c <= '0;
                            end else begin
                                c <= c + 1'b1;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                    if (fetch_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_POOL;
                end
                S_POOL: begin
                    // Window order (0,0),(0,1),(1,0),(1,1): dy innermost
                    if (dx && dy) begin
                        dx    <= 1'b0;
                        dy    <= 1'b0;
                        state <= S_EMIT;
                    end else if (dy) begin
                        dx    <= 1'b1;
                        dy    <= 1'b0;
                        state <= S_FETCH;
                    end else begin
                        dy    <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        if (pc == PC_LAST) begin
                            pc <= '0;
                            if (pr == PR_LAST) begin
                                pr <= '0;
                                if (f == F_LAST) begin
                                    f <= '0;
                                end else begin
                                    f <= f + 1'b1;
                                end
                            end else begin
                                pr <= pr + 1'b1;
                            end
                        end else begin
                            pc <= pc + 1'b1;
                        end
                        state <= res_last ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The accumulator consumes the data returned by the previous cycle's
    // read.
    // It is cleared when a pass is accepted and after each window's pool
    // step.
    // The running max clears when a pass is accepted and on each result
    // handshake.
    conv_mac_acc #(
        .IBW (IBW),
        .KBW (KBW),
        .OBW (OBW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .din     (in_data),
        .kin     (k_data),
        .acc_clr (start_acc || (state == S_POOL)),
        .acc_en  (rd_q),
        .pool_en (state == S_POOL),
        .max_clr (start_acc || hs),
        .max_q   (res_data)
    );

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// Directed bench for conv_pool_sequencer on a 4x4 input, 3x3 kernels, two filters (filter 1 = 2x filter 0).
// Each pass gives two pooled results: filter 0 at address 0 and filter 1 at address 1.
// The second result of a pass arrives 45 cycles after the first handshake.
module tb_conv_pool_sequencer;

    localparam int IBW = 8;
    localparam int KBW = 64;
    localparam int OBW = IBW + KBW;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic           in_rd_en;
    logic [3:0]     in_addr;
    logic [IBW-1:0] in_data;
    logic           k_rd_en;
    logic [4:0]     k_addr;
    logic [KBW:0]   k_data;
    logic           res_valid;
    logic           res_ready;
    logic [0:0]     res_addr;
    logic [OBW:0]   res_data;

    logic [IBW-1:0] in_mem [16];
    logic [KBW:0]   k_mem  [18];

    int checks = 0;
    int errors = 0;

    // Per-pass observations
    int           first_v, done_c, busy_low, nres, nseq, kmin, kmax, held;
    bit           stable_bad;
    logic [OBW:0] rd [2];
    logic [0:0]   ra [2];
    logic [3:0]   seq [9];
    logic [OBW:0] hd;
    logic [0:0]   ha;

    always #5 clk = ~clk;

    conv_pool_sequencer #(
        .IBW(IBW), .KBW(KBW), .OBW(OBW),
        .HEIGHT(4), .WIDTH(4), .CHANNELS(1), .FILTERS(2), .K_X(3), .K_Y(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
        .k_rd_en(k_rd_en), .k_addr(k_addr), .k_data(k_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_data(res_data)
    );

    // Synchronous RAM models with one-cycle read latency
    always @(posedge clk) begin
        if (in_rd_en) in_data <= in_mem[in_addr];
        if (k_rd_en)  k_data  <= k_mem[k_addr];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    // mode 0: in=1,  k=+1/+2    mode 1: in=1,  k=-1/-2
    // mode 2: in=r*4+c, centre tap only (+1/+2)    mode 3: in=-128, k=-1/-2
    task automatic load(input int mode);
        int iv, k0;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                2:       iv = i;
                3:       iv = -128;
                default: iv = 1;
            endcase
            in_mem[i] = 8'(iv);
        end
        for (int i = 0; i < 9; i++) begin
            case (mode)
                1, 3:    k0 = -1;
                2:       k0 = (i == 4) ? 1 : 0;
                default: k0 = 1;
            endcase
            k_mem[i]     = (KBW + 1)'(k0);
            k_mem[9 + i] = (KBW + 1)'(2 * k0);
        end
    endtask

    // The start pulse is cycle 0.
    // Observations are taken 1 time unit after each later rising edge,
    // where n names the cycle.
    task automatic run_pass(input int hold, input bit spam);
        nres = 0; first_v = -1; done_c = -1; busy_low = -1; nseq = 0;
        kmin = 999; kmax = -1; held = 0; stable_bad = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 400 && busy_low < 0; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (in_rd_en) begin
                if (nseq < 9) seq[nseq] = in_addr;
                nseq++;
            end
            if (k_rd_en) begin
                if (int'(k_addr) < kmin) kmin = int'(k_addr);
                if (int'(k_addr) > kmax) kmax = int'(k_addr);
            end
            if (res_valid) begin
                if (first_v < 0) first_v = n;
                if (spam) start = 1'b1;
                if (nres == 0 && held < hold) begin
                    if (held == 0) begin
                        hd = res_data;
                        ha = res_addr;
                    end else if (res_data !== hd || res_addr !== ha) begin
                        stable_bad = 1;
                    end
                    res_ready = 1'b0;
                    held++;
                end else begin
                    if (nres == 0 && held > 0 && (res_data !== hd || res_addr !== ha))
                        stable_bad = 1;
                    res_ready = 1'b1;
                    if (nres < 2) begin
                        rd[nres] = res_data;
                        ra[nres] = res_addr;
                    end
                    nres++;
                end
            end else begin
                res_ready = 1'b1;
            end
            if (done) begin
                if (done_c < 0) done_c = n;
                if (spam) start = 1'b1;
            end
            if (!busy && busy_low < 0) busy_low = n;
        end
        start     = 1'b0;
        res_ready = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_seq [9];
        exp_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};

        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        load(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_inrd",  in_rd_en, 0);
        chk("rst_krd",   k_rd_en, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_iaddr", in_addr, 0);
        chk("rst_kaddr", k_addr, 0);
        chk("rst_raddr", res_addr, 0);
        chk("rst_rdata", res_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: all ones
        load(0);
        run_pass(0, 0);
        chk("t1_nres",    nres, 2);
        chk("t1_first",   first_v, 45);
        chk("t1_d0",      rd[0], 9);
        chk("t1_a0",      ra[0], 0);
        chk("t1_d1",      rd[1], 18);
        chk("t1_a1",      ra[1], 1);
        chk("t1_done",    done_c, 91);
        chk("t1_busylow", busy_low, 92);

        // 2: negative kernel, ReLU clamps to zero
        load(1);
        run_pass(0, 0);
        chk("t2_d0", rd[0], 0);
        chk("t2_d1", rd[1], 0);

        // 3: ramp input, centre-tap kernel
        load(2);
        run_pass(0, 0);
        chk("t3_d0", rd[0], 10);
        chk("t3_d1", rd[1], 20);
        for (int i = 0; i < 9; i++) chk($sformatf("t3_inaddr%0d", i), seq[i], exp_seq[i]);

        // 4: backpressure on the first result for 5 cycles
        load(0);
        run_pass(5, 0);
        chk("t4_stable", stable_bad, 0);
        chk("t4_first",  first_v, 45);
        chk("t4_d0",     rd[0], 9);
        chk("t4_a0",     ra[0], 0);
        chk("t4_d1",     rd[1], 18);
        chk("t4_a1",     ra[1], 1);
        chk("t4_done",   done_c, 96);
        chk("t4_kmin",   kmin, 0);
        chk("t4_kmax",   kmax, 17);

        // 5: reset during the second window's fetch, then a clean rerun
        load(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("t5_pre_inrd",  in_rd_en, 1);
        chk("t5_pre_iaddr", in_addr, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy",  busy, 0);
        chk("t5_inrd",  in_rd_en, 0);
        chk("t5_krd",   k_rd_en, 0);
        chk("t5_valid", res_valid, 0);
        chk("t5_iaddr", in_addr, 0);
        chk("t5_kaddr", k_addr, 0);
        chk("t5_rdata", res_data, 0);
        @(negedge clk);
        rst = 1'b0;
        run_pass(0, 0);
        chk("t5_first", first_v, 45);
        chk("t5_d0",    rd[0], 9);
        chk("t5_d1",    rd[1], 18);
        chk("t5_done",  done_c, 91);

        // 6: full-scale negative input, start driven during EMIT and DONE
        load(3);
        run_pass(0, 1);
        chk("t6_first",    first_v, 45);
        chk("t6_d0",       rd[0], 1152);
        chk("t6_d1",       rd[1], 2304);
        chk("t6_done",     done_c, 91);
        chk("t6_busylow",  busy_low, 92);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_busy",  busy, 0);
        chk("t6_idle_valid", res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pool_sequencer.md
Name: conv_pool_sequencer

Overview:
Clocked controller for the conv + ReLU + 2x2 max-pool layer. It reads inputs and kernels one word per cycle from external RAMs and runs a single shared multiply-accumulate. It then applies ReLU, reduces each 2x2 window to its max, and streams pooled results to an output buffer. It replaces the fully unrolled combinational layer wherever area matters; the arithmetic and result ordering are bit-identical to that layer.

Parameters:
IBW, 8, input word width (signed)
KBW, 64, kernel magnitude width; kernel words are KBW+1 bits signed
OBW, IBW+KBW, result magnitude width; accumulator and result words are OBW+1 bits signed
HEIGHT, 28, input rows
WIDTH, 28, input cols
CHANNELS, 1, input channels
FILTERS, 32, output filters
K_X, 3, kernel rows
K_Y, 3, kernel cols
(derived) OUT_X=HEIGHT-K_X+1, OUT_Y=WIDTH-K_Y+1, PX=OUT_X/2, PY=OUT_Y/2 (floor), N=CHANNELS*K_X*K_Y

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a layer pass; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse after the last result handshake
in_rd_en  out  1  input RAM read strobe
in_addr  out  clog2(CHANNELS*HEIGHT*WIDTH)  c*HEIGHT*WIDTH + row*WIDTH + col
in_data  in  IBW  input word, valid exactly 1 cycle after in_rd_en
k_rd_en  out  1  kernel RAM read strobe
k_addr  out  clog2(FILTERS*N)  ((f*CHANNELS+c)*K_X+k)*K_Y+t
k_data  in  KBW+1  kernel word, 1-cycle latency
res_valid  out  1  pooled result available
res_ready  in  1  sink accepts result
res_addr  out  clog2(FILTERS*PX*PY)  f*PX*PY + pr*PY + pc
res_data  out  OBW+1  pooled result

Behaviour:
- Reset: state IDLE. busy, done, in_rd_en, k_rd_en and res_valid are 0. in_addr, k_addr, res_addr and res_data are 0. Accumulator, max register and all loop counters are 0.
- Reset mid-operation aborts immediately, with no partial emit. rst wins over start in the same cycle.
- States: IDLE -> FETCH -> DRAIN -> POOL -> (FETCH for next window position | EMIT) -> ... -> DONE -> IDLE.
- IDLE: start=1 -> FETCH. The accumulator and max register clear, and all counters go to 0.
- FETCH: exactly N cycles. Each cycle asserts in_rd_en and k_rd_en with one (c,k,t) address pair, in t-innermost, then k, then c order.
  - Input row = 2*pr+dx+k; input col = 2*pc+dy+t.
  - The accumulator adds the product of the data returned by the previous cycle's read, from FETCH cycle 2 onward.
- DRAIN: 1 cycle. The last product accumulates; no read strobes.
- POOL: 1 cycle.
  - relu = (acc<0) ? 0 : acc.
  - max <= (relu > max) ? relu : max.
  - acc <= 0.
  - Window position order: (dx,dy) = (0,0), (0,1), (1,0), (1,1).
  - After (1,1) go to EMIT; otherwise go to FETCH.
- EMIT: res_valid=1, with res_data=max and res_addr stable while res_ready=0.
  - On the valid&ready cycle, max clears and pc/pr/f advance, pc innermost.
  - After the final result go to DONE; otherwise go to FETCH.
- DONE: done=1 for 1 cycle, then IDLE. start in DONE is ignored.
- start while busy is ignored.
- Arithmetic:
  - Product is signed IBW x signed KBW+1, sign-extended to OBW+1.
  - Accumulation is modulo 2^(OBW+1), with no saturation.
  - Channel sums accumulate into the same accumulator.
- Odd OUT_X/OUT_Y: trailing row/col are never fetched.
- Throughput with res_ready held high: each pooled result takes 4*(N+2)+1 cycles. res_valid first rises 4*(N+2)+1 cycles after the start-accept edge.

Decomposition:
- Package conv_seq_pkg: state enum, and derived localparams (OUT_X, OUT_Y, PX, PY, N, address widths via clog2).
- Sub-module conv_mac_acc: signed multiply, OBW+1 accumulator with clear/enable, ReLU and running-max register. The sequencer owns only the FSM, counters and address generation.

Test Plan:
1. HEIGHT=WIDTH=4, FILTERS=1, inputs all 1, kernel all 1, res_ready=1, start at cycle 0.
   - res_valid in cycle 45 with res_data=9, res_addr=0.
   - done pulses in cycle 46.
   - busy low in cycle 47.
2. Same config, kernel all -1 -> res_data=0 (ReLU).
3. Inputs in[r][c]=r*4+c, kernel centre=1 and others 0.
   - Window values 5, 6, 9, 10 -> res_data=10.
   - in_addr sequence for the first FETCH is 0, 1, 2, 4, 5, 6, 8, 9, 10.
4. FILTERS=2, second filter scaled x2, res_ready low for 5 cycles while valid.
   - res_data/res_addr stay stable while held.
   - Results 9@addr0, then 18@addr1.
   - done is delayed by exactly 5 cycles.
   - k_addr spans 0..17.
5. rst asserted during FETCH of the second window position.
   - All outputs return to 0 the next cycle.
   - A fresh start reproduces test 1's results and timing exactly.
6. Input -128 everywhere with kernel -1 (product +128), checked for no truncation -> res_data=1152.
   - Also drive start during EMIT and DONE -> no effect.
